// File: rtl/jtag_axi_pkg.sv
// Shared JTAG-to-AXI types: IR codes, response status, request/response records.
package jtag_axi_pkg;

  localparam int AXI_ADDR_W           = 32;
  localparam int AXI_DATA_W           = 32;
  localparam int SLOT_W               = 3;
  localparam int AXI_ASYNC_FIFO_DEPTH = 4;

  localparam logic [SLOT_W-1:0] FIFO_FULL_SLOTS = SLOT_W'(AXI_ASYNC_FIFO_DEPTH);

  localparam logic [2:0] IR_ADDR        = 3'd1;
  localparam logic [2:0] IR_DATA_W      = 3'd2;
  localparam logic [2:0] IR_WSTRB       = 3'd3;
  localparam logic [2:0] IR_CTRL_STATUS = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUNNING = 3'd1,
    ST_OKAY    = 3'd2,
    ST_EXOKAY  = 3'd3,
    ST_SLVERR  = 3'd4,
    ST_DECERR  = 3'd5,
    ST_TIMEOUT = 3'd6
  } axi_status_e;

  typedef struct packed {
    logic [2:0] size;
    logic       txn_type;
    logic       start;
  } s_axi_jtag_ctrl_t;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0]   addr;
    logic [AXI_DATA_W-1:0]   data_wr;
    logic [AXI_DATA_W/8-1:0] wstrb;
    s_axi_jtag_ctrl_t        ctrl;
  } s_axi_jtag_info_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data_rd;
    axi_status_e           status;
  } s_axi_jtag_status_t;

  // Only completed transactions consume a response entry.
  function automatic logic status_pops(axi_status_e s);
    return (s == ST_OKAY) || (s == ST_EXOKAY) || (s == ST_SLVERR) || (s == ST_DECERR);
  endfunction

endpackage

// File: rtl/jtag_axi_dr_ctrl.sv
// JTAG data-register block feeding AXI requests: ADDR, DATA_W, WSTRB, CTRL_STATUS, BYPASS.
// Define JTAG_AXI_DR_FULL_GUARD_EN to block requests into a full command FIFO (sticky ovf flag).
module jtag_axi_dr_ctrl
  import jtag_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               tck,
  input  logic               trstn,
  input  logic [2:0]         ir_sel_i,
  input  logic               capture_dr_i,
  input  logic               shift_dr_i,
  input  logic               update_dr_i,
  input  logic               tdi_i,
  output logic               tdo_o,
  input  s_axi_jtag_status_t jtag_status_i,
  input  logic [SLOT_W-1:0]  afifo_slots_i,
  output s_axi_jtag_info_t   axi_info_o,
  output logic               axi_req_new_o,
  output logic               axi_status_rd_o
);

  localparam int SR_W   = DATA_W + SLOT_W + 4;
  localparam int STRB_W = DATA_W / 8;

  logic [SR_W-1:0]  shift_q, shift_d;
  logic [SR_W-1:0]  cap_val, shift_val, shifted;
  s_axi_jtag_info_t info_q, info_d;
  logic             req_q, req_d;
  logic             pop_q, pop_d;
  logic             ovf_q, ovf_d;
  int               dr_len;

  always_comb begin
    dr_len  = 1;
    cap_val = '0;
    case (ir_sel_i)
      IR_ADDR: begin
        dr_len               = ADDR_W;
        cap_val[ADDR_W-1:0]  = info_q.addr;
      end
      IR_DATA_W: begin
        dr_len               = DATA_W;
        cap_val[DATA_W-1:0]  = info_q.data_wr;
      end
      IR_WSTRB: begin
        dr_len               = STRB_W;
        cap_val[STRB_W-1:0]  = info_q.wstrb;
      end
      IR_CTRL_STATUS: begin
        dr_len  = SR_W;
        cap_val = {jtag_status_i.data_rd, afifo_slots_i, ovf_q, jtag_status_i.status};
      end
      default: begin
        dr_len  = 1;
        cap_val = '0;
      end
    endcase
  end

  // tdi enters at the top of the selected DR; bits above its length are held at zero.
  always_comb begin
    shifted   = {1'b0, shift_q[SR_W-1:1]};
    shift_val = '0;
    for (int i = 0; i < SR_W; i++) begin
      if (i < dr_len - 1)       shift_val[i] = shifted[i];
      else if (i == dr_len - 1) shift_val[i] = tdi_i;
      else                      shift_val[i] = 1'b0;
    end
  end

  always_comb begin
    shift_d = shift_q;
    info_d  = info_q;
    req_d   = 1'b0;
    pop_d   = 1'b0;
    ovf_d   = ovf_q;
    if (capture_dr_i) begin
      shift_d = cap_val;
      if (ir_sel_i == IR_CTRL_STATUS) begin
        pop_d = status_pops(jtag_status_i.status);
        ovf_d = 1'b0;
      end
    end else if (shift_dr_i) begin
      shift_d = shift_val;
    end else if (update_dr_i) begin
      case (ir_sel_i)
        IR_ADDR:   info_d.addr    = shift_q[ADDR_W-1:0];
        IR_DATA_W: info_d.data_wr = shift_q[DATA_W-1:0];
        IR_WSTRB:  info_d.wstrb   = shift_q[STRB_W-1:0];
        IR_CTRL_STATUS: begin
          info_d.ctrl = s_axi_jtag_ctrl_t'(shift_q[4:0]);
          if (shift_q[0]) begin
`ifdef JTAG_AXI_DR_FULL_GUARD_EN
            if (afifo_slots_i == FIFO_FULL_SLOTS) ovf_d = 1'b1;
            else                                  req_d = 1'b1;
`else
            req_d = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
`ifndef JTAG_AXI_DR_FULL_GUARD_EN
    ovf_d = 1'b0;
`endif
  end

  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      shift_q <= '0;
      info_q  <= '{addr: '0, data_wr: '0, wstrb: '1, ctrl: '0};
      req_q   <= 1'b0;
      pop_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      info_q  <= info_d;
      req_q   <= req_d;
      pop_q   <= pop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tdo_o           = shift_q[0];
  assign axi_info_o      = info_q;
  assign axi_req_new_o   = req_q;
  assign axi_status_rd_o = pop_q;

endmodule
